alu_sweep_driver: RTL and testbench
===================================

Name: alu_sweep_driver

Overview:
- Synthesizable driver side of the mini_alu operand/opcode interface.
- On `start`, latches one operand set and presents it to the ALU with every opcode in turn.
- Captures the ALU's combinational `y`/`flags` response for each opcode into an internal result buffer, and counts Z-flag hits.
- Sits beside mini_alu as on-chip self-test and sweep capture for the datapath; results are read back through a registered read port.

Parameters:
- DATA_W, 32, operand/result width
- OP_W, 4, opcode width
- NUM_OPS, 16, opcodes swept (0 to NUM_OPS-1); must be ≤ 2**OP_W
- DWELL, 2, cycles each opcode is held before its result is sampled; must be ≥ 1

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a sweep; honoured only when not busy
- a_in  input  DATA_W  operand A to latch
- b_in  input  DATA_W  operand B to latch
- cin_in  input  1  carry-in to latch
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when the sweep completes
- alu_a  output  DATA_W  to mini_alu a
- alu_b  output  DATA_W  to mini_alu b
- alu_cin  output  1  to mini_alu cin
- alu_opcode  output  OP_W  to mini_alu opcode
- alu_y  input  DATA_W  from mini_alu y (combinational)
- alu_flags  input  4  from mini_alu flags: [3]=N, [2]=Z, [1]=V, [0]=C
- rd_addr  input  OP_W  buffer read index
- rd_y  output  DATA_W  buffered y at rd_addr
- rd_flags  output  4  buffered flags at rd_addr
- z_count  output  $clog2(NUM_OPS+1)  number of opcodes in the last sweep with Z=1

Behaviour:
- Reset (synchronous, active-high) sets:
  - state IDLE;
  - busy, done = 0;
  - alu_a, alu_b, alu_cin, alu_opcode = 0;
  - all buffer entries = 0;
  - rd_y, rd_flags, z_count = 0;
  - dwell counter = 0.
- Reset takes priority over all other inputs.
- Reset mid-sweep aborts the sweep: no done pulse, partial results discarded.
- States:
  - IDLE: busy=0. If start=1 at edge E0:
    - latch a_in/b_in/cin_in onto alu_a/alu_b/alu_cin;
    - set alu_opcode=0, z_count=0, dwell counter=0;
    - go to DRIVE; busy=1 from E0.
  - DRIVE: each edge increments the dwell counter.
    - When the counter reaches DWELL-1, that edge writes alu_y/alu_flags into buffer[alu_opcode] and adds alu_flags[2] to z_count.
    - On that same edge: if alu_opcode < NUM_OPS-1, increment alu_opcode and clear the counter; otherwise go to FINISH.
  - FINISH: done=1 for exactly this one cycle, busy=0. Next edge returns to IDLE with done=0.
- Timing:
  - Opcode k is sampled at edge E0 + (k+1)*DWELL.
  - done is high during the cycle after edge E0 + NUM_OPS*DWELL.
- alu_a/alu_b/alu_cin hold their latched values after the sweep, until the next accepted start or reset. alu_opcode holds NUM_OPS-1.
- start while busy (DRIVE) is ignored; operands are not re-latched.
- start during FINISH is also ignored. A new sweep can be accepted in the IDLE cycle immediately after.
- Read port:
  - rd_y/rd_flags are registered, 1-cycle latency from rd_addr.
  - Reads are allowed at any time, including during a sweep, and return the current buffer contents. An entry for opcode k updates at its sample edge.
  - A read and a write of the same entry on the same edge return the old value.
  - rd_addr ≥ NUM_OPS returns 0.
- z_count saturates at NUM_OPS. It is cleared only by reset or an accepted start.
- Width rules: alu_y is stored unmodified; no arithmetic is performed on data.

Test Plan:
All scenarios use a bench ALU stub: y = a + opcode, flags = {1'b0, (a+opcode)==0, 1'b0, cin}.
1. Reset, then start with a=32'h0000_0010, b=1, cin=1, DWELL=2 → busy rises at E0; opcode steps 0..15 every 2 cycles; done pulses once after edge E0+32; buffer[k] reads y=16+k, flags=4'b0001; z_count=0.
2. a=32'hFFFF_FFFB, cin=0 → buffer[5] y=0, flags=4'b0100; buffer[6] y=1; z_count=1; rd_* valid one cycle after rd_addr.
3. Pulse start again at sweep cycle 7 with a different a_in → ignored; alu_a is unchanged and done occurs at the original time; start in the IDLE cycle after done is accepted.
4. Assert reset at sweep cycle 10 → busy=0 next edge; no done pulse; all 16 buffer entries read 0; z_count=0.
5. DWELL=1 sweep → done exactly NUM_OPS+1 cycles after start; rd_addr=3 issued on buffer[3]'s write edge returns the previous value, and the new value one read later.

Source files
------------

// File: rtl/alu_sweep_driver.sv
// Sweeps every opcode over one latched operand set and captures each ALU response.
// Each opcode is held for DWELL cycles. Results are read back through a registered read port.
module alu_sweep_driver #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int NUM_OPS = 16,
  parameter int DWELL   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_W-1:0]              a_in,
  input  logic [DATA_W-1:0]              b_in,
  input  logic                           cin_in,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_W-1:0]              alu_a,
  output logic [DATA_W-1:0]              alu_b,
  output logic                           alu_cin,
  output logic [OP_W-1:0]                alu_opcode,
  input  logic [DATA_W-1:0]              alu_y,
  input  logic [3:0]                     alu_flags,
  input  logic [OP_W-1:0]                rd_addr,
  output logic [DATA_W-1:0]              rd_y,
  output logic [3:0]                     rd_flags,
  output logic [$clog2(NUM_OPS+1)-1:0]   z_count
);

  localparam int ZW = $clog2(NUM_OPS + 1);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     dwell_cnt;
  logic              sample;
  logic              last_op;
  logic [DATA_W-1:0] buf_y     [NUM_OPS];
  logic [3:0]        buf_flags [NUM_OPS];

  always_comb begin
    sample    = 1'b0;
    last_op   = 1'b0;
    state_nxt = state;
    sample    = (state == DRIVE) && (dwell_cnt == CW'(DWELL - 1));
    last_op   = !(alu_opcode < OP_W'(NUM_OPS - 1));
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (sample && last_op) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == DRIVE);
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_opcode <= '0;
      dwell_cnt  <= '0;
      z_count    <= '0;
      rd_y       <= '0;
      rd_flags   <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        buf_y[i]     <= '0;
        buf_flags[i] <= '0;
      end
    end else begin
      state <= state_nxt;

      if (state == IDLE && start) begin
        alu_a      <= a_in;
        alu_b      <= b_in;
        alu_cin    <= cin_in;
        alu_opcode <= '0;
        dwell_cnt  <= '0;
        z_count    <= '0;
      end

      // Sample on the last dwell cycle; the final opcode stays on the bus afterwards.
      if (state == DRIVE) begin
        if (sample) begin
          buf_y[alu_opcode]     <= alu_y;
          buf_flags[alu_opcode] <= alu_flags;
          if (z_count != ZW'(NUM_OPS))
            z_count <= z_count + ZW'(alu_flags[2]);
          if (!last_op) begin
            alu_opcode <= alu_opcode + 1'b1;
            dwell_cnt  <= '0;
          end
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end

      // Nonblocking read sees the pre-write contents when addressing the entry being sampled.
      if (int'(rd_addr) < NUM_OPS) begin
        rd_y     <= buf_y[rd_addr];
        rd_flags <= buf_flags[rd_addr];
      end else begin
        rd_y     <= '0;
        rd_flags <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Bench for alu_sweep_driver: two instances (DWELL=2 and DWELL=1) driven against an adder stub ALU.
module tb_alu_sweep_driver;

  localparam int DW   = 32;
  localparam int OPW  = 4;
  localparam int NOPS = 16;
  localparam int ZW   = $clog2(NOPS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start2 = 1'b0;
  logic          start1 = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          cin_in = 1'b0;
  logic [OPW-1:0] rd_addr = '0;

  logic busy2, done2, cin2, busy1, done1, cin1;
  logic [DW-1:0]  a2, b2, y2, rdy2, a1, b1, y1, rdy1;
  logic [OPW-1:0] op2, op1;
  logic [3:0]     fl2, rdf2, fl1, rdf1;
  logic [ZW-1:0]  zc2, zc1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl_y2 [NOPS];
  logic [3:0]    mdl_f2 [NOPS];
  logic [DW-1:0] mdl_y1 [NOPS];
  logic [3:0]    mdl_f1 [NOPS];
  int            mdl_z2, mdl_z1;

  always #5 clk = ~clk;

  // Stub ALU: y = a + opcode, flags = {N=0, Z, V=0, C=cin}.
  assign y2  = a2 + {{(DW-OPW){1'b0}}, op2};
  assign fl2 = {1'b0, (y2 == '0), 1'b0, cin2};
  assign y1  = a1 + {{(DW-OPW){1'b0}}, op1};
  assign fl1 = {1'b0, (y1 == '0), 1'b0, cin1};

  alu_sweep_driver #(.DATA_W(DW), .OP_W(OPW), .NUM_OPS(NOPS), .DWELL(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .busy(busy2), .done(done2), .alu_a(a2), .alu_b(b2), .alu_cin(cin2), .alu_opcode(op2),
    .alu_y(y2), .alu_flags(fl2), .rd_addr(rd_addr), .rd_y(rdy2), .rd_flags(rdf2), .z_count(zc2)
  );

  alu_sweep_driver #(.DATA_W(DW), .OP_W(OPW), .NUM_OPS(NOPS), .DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .busy(busy1), .done(done1), .alu_a(a1), .alu_b(b1), .alu_cin(cin1), .alu_opcode(op1),
    .alu_y(y1), .alu_flags(fl1), .rd_addr(rd_addr), .rd_y(rdy1), .rd_flags(rdf1), .z_count(zc1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] ref_y(input logic [DW-1:0] a, input int k);
    return a + DW'(k);
  endfunction

  function automatic logic [3:0] ref_f(input logic [DW-1:0] a, input int k, input logic cin);
    return {1'b0, (ref_y(a, k) == '0), 1'b0, cin};
  endfunction

  task automatic clear_models();
    for (int k = 0; k < NOPS; k++) begin
      mdl_y2[k] = '0; mdl_f2[k] = '0; mdl_y1[k] = '0; mdl_f1[k] = '0;
    end
    mdl_z2 = 0;
    mdl_z1 = 0;
  endtask

  task automatic commit2(input logic [DW-1:0] a, input logic cin);
    mdl_z2 = 0;
    for (int k = 0; k < NOPS; k++) begin
      mdl_y2[k] = ref_y(a, k);
      mdl_f2[k] = ref_f(a, k, cin);
      if (ref_y(a, k) == '0) mdl_z2++;
    end
  endtask

  task automatic commit1(input logic [DW-1:0] a, input logic cin);
    mdl_z1 = 0;
    for (int k = 0; k < NOPS; k++) begin
      mdl_y1[k] = ref_y(a, k);
      mdl_f1[k] = ref_f(a, k, cin);
      if (ref_y(a, k) == '0) mdl_z1++;
    end
  endtask

  task automatic read_all2(input string tag);
    for (int k = 0; k < NOPS; k++) begin
      rd_addr = OPW'(k);
      tick();
      checks++;
      if (rdy2 !== mdl_y2[k] || rdf2 !== mdl_f2[k]) begin
        errors++;
        $display("FAIL %s rd2[%0d]: got y=%h f=%b, want y=%h f=%b", tag, k, rdy2, rdf2, mdl_y2[k], mdl_f2[k]);
      end
    end
  endtask

  task automatic read_all1(input string tag);
    for (int k = 0; k < NOPS; k++) begin
      rd_addr = OPW'(k);
      tick();
      checks++;
      if (rdy1 !== mdl_y1[k] || rdf1 !== mdl_f1[k]) begin
        errors++;
        $display("FAIL %s rd1[%0d]: got y=%h f=%b, want y=%h f=%b", tag, k, rdy1, rdf1, mdl_y1[k], mdl_f1[k]);
      end
    end
  endtask

  // One DWELL=2 sweep; optionally pulses start with a different operand at cycle inj_cyc.
  task automatic run2(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                      input int inj_cyc, input logic [DW-1:0] inj_a);
    int exp_op;
    a_in = a; b_in = b; cin_in = cin; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1 || a2 !== a || b2 !== b || cin2 !== cin || op2 !== '0) begin
      errors++;
      $display("FAIL sweep2_accept: busy=%b a=%h b=%h cin=%b op=%0d, want 1 %h %h %b 0",
               busy2, a2, b2, cin2, op2, a, b, cin);
    end
    for (int n = 1; n <= 2 * NOPS + 1; n++) begin
      if (n == inj_cyc) begin
        start2 = 1'b1;
        a_in   = inj_a;
      end
      tick();
      start2 = 1'b0;
      exp_op = (n / 2 > NOPS - 1) ? NOPS - 1 : n / 2;
      checks++;
      if (done2 !== (n == 2 * NOPS) || busy2 !== (n < 2 * NOPS)) begin
        errors++;
        $display("FAIL sweep2_ctrl n=%0d: done=%b busy=%b, want %b %b", n, done2, busy2,
                 (n == 2 * NOPS), (n < 2 * NOPS));
      end
      checks++;
      if (op2 !== OPW'(exp_op) || a2 !== a) begin
        errors++;
        $display("FAIL sweep2_bus n=%0d: op=%0d a=%h, want %0d %h", n, op2, a2, exp_op, a);
      end
    end
    commit2(a, cin);
    checks++;
    if (zc2 !== ZW'(mdl_z2)) begin
      errors++;
      $display("FAIL sweep2_zcount: got %0d, want %0d", zc2, mdl_z2);
    end
  endtask

  task automatic test_reset();
    a_in = 32'h1234_5678; b_in = 32'h9abc_def0; cin_in = 1'b1;
    reset = 1'b1; start2 = 1'b1; start1 = 1'b1;
    tick(); tick();
    start2 = 1'b0; start1 = 1'b0;
    reset = 1'b0;
    clear_models();
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy2=%b done2=%b busy1=%b done1=%b, want 0", busy2, done2, busy1, done1);
    end
    checks++;
    if (a2 !== '0 || b2 !== '0 || cin2 !== 1'b0 || op2 !== '0) begin
      errors++;
      $display("FAIL reset_bus: a=%h b=%h cin=%b op=%0d, want 0", a2, b2, cin2, op2);
    end
    checks++;
    if (zc2 !== '0 || rdy2 !== '0 || rdf2 !== '0 || zc1 !== '0) begin
      errors++;
      $display("FAIL reset_regs: zc2=%0d rdy=%h rdf=%b zc1=%0d, want 0", zc2, rdy2, rdf2, zc1);
    end
    read_all2("reset");
  endtask

  task automatic test_basic();
    run2(32'h0000_0010, 32'h1, 1'b1, 0, '0);
    read_all2("basic");
    checks++;
    if (zc2 !== '0) begin
      errors++;
      $display("FAIL basic_zcount: got %0d, want 0", zc2);
    end
  endtask

  task automatic test_zero_hit();
    run2(32'hFFFF_FFFB, 32'h7, 1'b0, 0, '0);
    rd_addr = 4'd5;
    tick();
    checks++;
    if (rdy2 !== 32'h0 || rdf2 !== 4'b0100) begin
      errors++;
      $display("FAIL zero_hit_entry5: y=%h f=%b, want 00000000 0100", rdy2, rdf2);
    end
    rd_addr = 4'd6;
    tick();
    checks++;
    if (rdy2 !== 32'h1 || rdf2 !== 4'b0000) begin
      errors++;
      $display("FAIL zero_hit_entry6: y=%h f=%b, want 00000001 0000", rdy2, rdf2);
    end
    checks++;
    if (zc2 !== ZW'(1)) begin
      errors++;
      $display("FAIL zero_hit_zcount: got %0d, want 1", zc2);
    end
    read_all2("zero_hit");
  endtask

  task automatic test_start_ignored();
    run2(32'h0000_0100, 32'h2, 1'b1, 7, 32'hDEAD_BEEF);
    // Accepted in the IDLE cycle right after done; start during FINISH is ignored.
    run2(32'h0000_0200, 32'h3, 1'b0, 2 * NOPS + 1, 32'hCAFE_F00D);
    read_all2("start_ignored");
  endtask

  task automatic test_random();
    logic [DW-1:0] a;
    for (int r = 0; r < 4; r++) begin
      a = (r % 2 == 0) ? DW'($urandom) : (32'h0 - DW'($urandom_range(0, NOPS - 1)));
      run2(a, DW'($urandom), 1'($urandom_range(0, 1)), 0, '0);
      read_all2("random");
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    a_in = DW'($urandom); start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_models();
    checks++;
    if (busy2 !== 1'b0 || zc2 !== '0 || a2 !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b zc=%0d a=%h, want 0 0 0", busy2, zc2, a2);
    end
    seen_done = 1'b0;
    for (int n = 0; n < 3 * NOPS; n++) begin
      tick();
      if (done2 === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_done: done pulse seen=%b, want 0", seen_done);
    end
    read_all2("reset_mid");
  endtask

  task automatic run1(input logic [DW-1:0] a, input logic cin);
    logic [DW-1:0] old_y;
    logic [3:0]    old_f;
    old_y = mdl_y1[3];
    old_f = mdl_f1[3];
    rd_addr = 4'd3;
    a_in = a; b_in = DW'($urandom); cin_in = cin; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || a1 !== a) begin
      errors++;
      $display("FAIL sweep1_accept: busy=%b a=%h, want 1 %h", busy1, a1, a);
    end
    for (int n = 1; n <= NOPS + 1; n++) begin
      tick();
      checks++;
      if (done1 !== (n == NOPS) || busy1 !== (n < NOPS)) begin
        errors++;
        $display("FAIL sweep1_ctrl n=%0d: done=%b busy=%b, want %b %b", n, done1, busy1,
                 (n == NOPS), (n < NOPS));
      end
      if (n == 4) begin
        checks++;
        if (rdy1 !== old_y || rdf1 !== old_f) begin
          errors++;
          $display("FAIL sweep1_rd_same_edge: y=%h f=%b, want %h %b", rdy1, rdf1, old_y, old_f);
        end
      end
      if (n == 5) begin
        checks++;
        if (rdy1 !== ref_y(a, 3) || rdf1 !== ref_f(a, 3, cin)) begin
          errors++;
          $display("FAIL sweep1_rd_next: y=%h f=%b, want %h %b", rdy1, rdf1, ref_y(a, 3), ref_f(a, 3, cin));
        end
      end
    end
    commit1(a, cin);
    checks++;
    if (zc1 !== ZW'(mdl_z1)) begin
      errors++;
      $display("FAIL sweep1_zcount: got %0d, want %0d", zc1, mdl_z1);
    end
    read_all1("dwell1");
  endtask

  task automatic test_dwell1();
    run1(DW'($urandom), 1'b1);
    run1(32'h0 - 32'd3, 1'b0);
    run1(DW'($urandom), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_hit();
    test_start_ignored();
    test_random();
    test_reset_mid();
    test_dwell1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
